seg7_scan6: RTL and testbench

Time-multiplexed six-digit 7-segment display driver for the digital clock. Consumes packed-BCD hour, minute and second values from the clock counter chain and scans them onto a common-anode display, one digit per slot. Provides dead-time anti-ghosting, tear-free frame snapshots, per-digit blinking for time-set mode, a colon separator and hour leading-zero blanking.

---
 rtl/seg7_scan6.sv | 148 ++++++++++++++
 tb/tb_seg7_scan6.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan6.sv
// seg7_scan6: six-digit multiplexed common-anode 7-segment driver
// with dead-time, frame snapshots, blinking, colon and hour LZB.
module seg7_scan6 #(
  parameter int SCAN_DIV     = 50000,
  parameter int DEAD         = 2,
  parameter int BLINK_FRAMES = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] hour,
  input  logic [7:0] min,
  input  logic [7:0] sec,
  input  logic [5:0] blink_mask,
  input  logic       colon,
  input  logic       lzb,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          ph_q, ph_d;
  logic [23:0]   snap_q, snap_d;
  logic          pend_q, pend_d;
  logic [5:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic          slot_end;
  logic          frame_end;
  logic          in_dead;
  logic [3:0]    nib;
  logic [6:0]    dec;
  logic          blank;
  logic [7:0]    mask8;

  if (DEAD == 0) begin : g_nodead
    assign in_dead = 1'b0;
  end else begin : g_dead
    assign in_dead = cnt_q < CW'(DEAD);
  end

  assign slot_end  = cnt_q == CW'(SCAN_DIV - 1);
  assign frame_end = slot_end && (idx_q == 3'd5);
  assign mask8     = {2'b00, blink_mask};

  always_comb begin
    cnt_d  = slot_end ? '0 : cnt_q + CW'(1);
    idx_d  = idx_q;
    fcnt_d = fcnt_q;
    ph_d   = ph_q;
    snap_d = snap_q;
    pend_d = 1'b0;
    if (slot_end) begin
      idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
    end
    if (frame_end) begin
      if (fcnt_q == FW'(BLINK_FRAMES - 1)) begin
        fcnt_d = '0;
        ph_d   = ~ph_q;
      end else begin
        fcnt_d = fcnt_q + FW'(1);
      end
    end
    // Load only at frame edges so no frame mixes old and new time
    if (frame_end || pend_q) begin
      snap_d = {hour, min, sec};
    end
  end

  always_comb begin
    nib = 4'h0;
    unique case (idx_q)
      3'd0:    nib = snap_q[23:20];
      3'd1:    nib = snap_q[19:16];
      3'd2:    nib = snap_q[15:12];
      3'd3:    nib = snap_q[11:8];
      3'd4:    nib = snap_q[7:4];
      3'd5:    nib = snap_q[3:0];
      default: nib = 4'h0;
    endcase
  end

  always_comb begin
    dec = 7'h3F;
    case (nib)
      4'd0:    dec = 7'h40;
      4'd1:    dec = 7'h79;
      4'd2:    dec = 7'h24;
      4'd3:    dec = 7'h30;
      4'd4:    dec = 7'h19;
      4'd5:    dec = 7'h12;
      4'd6:    dec = 7'h02;
      4'd7:    dec = 7'h78;
      4'd8:    dec = 7'h00;
      4'd9:    dec = 7'h10;
      default: dec = 7'h3F;
    endcase
  end

  assign blank = (ph_q && mask8[idx_q]) ||
                 ((idx_q == 3'd0) && lzb && (nib == 4'h0));

  always_comb begin
    an_d  = 6'h3F;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (!in_dead) begin
      an_d  = ~(6'b000001 << idx_q);
      seg_d = blank ? 7'h7F : dec;
      dp_d  = ~(colon && ((idx_q == 3'd1) || (idx_q == 3'd3)));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      idx_q  <= 3'd0;
      fcnt_q <= '0;
      ph_q   <= 1'b0;
      snap_q <= 24'h0;
      pend_q <= 1'b1;
      an_q   <= 6'h3F;
      seg_q  <= 7'h7F;
      dp_q   <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      fcnt_q <= fcnt_d;
      ph_q   <= ph_d;
      snap_q <= snap_d;
      pend_q <= pend_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan6.sv
// tb_seg7_scan6: two configurations of seg7_scan6 against a
// time-indexed display model plus hand-computed pins.
module tb_seg7_scan6;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] hour, min, sec;
  logic [5:0] blink_mask;
  logic       colon, lzb;
  logic [5:0] an_a, an_b;
  logic [6:0] seg_a, seg_b;
  logic       dp_a, dp_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seg7_scan6 #(.SCAN_DIV(4), .DEAD(1), .BLINK_FRAMES(2)) ua (
    .clk(clk), .reset(reset), .hour(hour), .min(min), .sec(sec),
    .blink_mask(blink_mask), .colon(colon), .lzb(lzb),
    .an(an_a), .seg(seg_a), .dp(dp_a)
  );

  seg7_scan6 #(.SCAN_DIV(2), .DEAD(0), .BLINK_FRAMES(1)) ub (
    .clk(clk), .reset(reset), .hour(hour), .min(min), .sec(sec),
    .blink_mask(blink_mask), .colon(colon), .lzb(lzb),
    .an(an_b), .seg(seg_b), .dp(dp_b)
  );

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  // Display after n cycles since release: {an, seg, dp}
  function automatic logic [13:0] model(
    input int n, input int sd, input int dead, input int bf,
    input logic [23:0] s, input logic [5:0] m,
    input logic c, input logic l);
    int cnt, idx, fr;
    logic ph, blank;
    logic [3:0] d;
    logic [5:0] a;
    logic [6:0] g;
    logic p;
    cnt = n % sd;
    idx = (n / sd) % 6;
    fr  = n / (6 * sd);
    ph  = ((fr / bf) % 2) == 1;
    if (cnt < dead) return {6'h3F, 7'h7F, 1'b1};
    d = s[23 - 4 * idx -: 4];
    blank = (ph && m[idx]) || (idx == 0 && l && d == 4'h0);
    g = blank ? 7'h7F : glyph(d);
    a = 6'h3F;
    a[idx] = 1'b0;
    p = !(c && (idx == 1 || idx == 3));
    return {a, g, p};
  endfunction

  int          na = 0, nb = 0;
  logic [23:0] sa, sb;
  logic [13:0] ea, eb;
  bit          mv = 0;

  always @(posedge clk) begin
    if (reset) begin
      ea = {6'h3F, 7'h7F, 1'b1};
      eb = {6'h3F, 7'h7F, 1'b1};
      na = 0; nb = 0;
      sa = '0; sb = '0;
      mv = 1;
    end else if (mv) begin
      ea = model(na, 4, 1, 2, sa, blink_mask, colon, lzb);
      eb = model(nb, 2, 0, 1, sb, blink_mask, colon, lzb);
      if (na == 0 || na % 24 == 23) sa = {hour, min, sec};
      if (nb == 0 || nb % 12 == 11) sb = {hour, min, sec};
      na++; nb++;
    end
  end

  task automatic chk(input string nm, input logic [13:0] got,
                     input logic [13:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got an=%h seg=%h dp=%b want an=%h seg=%h dp=%b",
               nm, got[13:8], got[7:1], got[0],
               want[13:8], want[7:1], want[0]);
    end
  endtask

  always @(negedge clk) begin
    if (mv) begin
      chk("model_a", {an_a, seg_a, dp_a}, ea);
      chk("model_b", {an_b, seg_b, dp_b}, eb);
      total++;
      if ($countones(~an_a) > 1 || $countones(~an_b) > 1) begin
        bad++;
        $display("FAIL onehot got an_a=%h an_b=%h want <=1 low",
                 an_a, an_b);
      end
      if (nb > 0) begin
        total++;
        if (an_b === 6'h3F) begin
          bad++;
          $display("FAIL nodead_b got an=%h want not 3F", an_b);
        end
      end
    end
  end

  task automatic go(input int k);
    int lim;
    lim = 0;
    while (na != k + 1 && lim < 1000) begin
      @(negedge clk);
      lim++;
    end
    if (na != k + 1) begin
      total++;
      bad++;
      $display("FAIL timeout got n=%0d want n=%0d", na - 1, k);
    end
  endtask

  task automatic pin(input string nm, input logic [5:0] a,
                     input logic [6:0] g, input logic p);
    chk(nm, {an_a, seg_a, dp_a}, {a, g, p});
  endtask

  initial begin
    reset = 1'b1;
    hour = 8'h12; min = 8'h34; sec = 8'h56;
    blink_mask = 6'h03; colon = 1'b0; lzb = 1'b0;
    repeat (3) @(negedge clk);
    pin("rst_a", 6'h3F, 7'h7F, 1'b1);
    chk("rst_b", {an_b, seg_b, dp_b}, {6'h3F, 7'h7F, 1'b1});
    reset = 1'b0;
    go(0);   pin("n0_dead", 6'h3F, 7'h7F, 1'b1);
    chk("b_n0", {an_b, seg_b, dp_b}, {6'h3E, 7'h40, 1'b1});
    go(1);   pin("d0", 6'h3E, 7'h79, 1'b1);
    go(5);   pin("d1", 6'h3D, 7'h24, 1'b1);
    go(9);   pin("d2", 6'h3B, 7'h30, 1'b1);
    sec = 8'h57;
    go(13);  pin("d3", 6'h37, 7'h19, 1'b1);
    go(17);  pin("d4", 6'h2F, 7'h12, 1'b1);
    go(21);  pin("d5_old", 6'h1F, 7'h02, 1'b1);
    go(24);  pin("f1_dead", 6'h3F, 7'h7F, 1'b1);
    go(25);  pin("f1_d0", 6'h3E, 7'h79, 1'b1);
    go(45);  pin("d5_new", 6'h1F, 7'h78, 1'b1);
    go(49);  pin("blk_d0", 6'h3E, 7'h7F, 1'b1);
    go(53);  pin("blk_d1", 6'h3D, 7'h7F, 1'b1);
    go(57);  pin("blk_d2", 6'h3B, 7'h30, 1'b1);
    go(97);  pin("unblk_d0", 6'h3E, 7'h79, 1'b1);
    go(145); pin("blk6_d0", 6'h3E, 7'h7F, 1'b1);
    go(150);
    colon = 1'b1; lzb = 1'b1; hour = 8'h08; min = 8'h4A;
    blink_mask = 6'h00;
    go(169); pin("lzb_d0", 6'h3E, 7'h7F, 1'b1);
    go(172); pin("col_dead", 6'h3F, 7'h7F, 1'b1);
    go(173); pin("col_d1", 6'h3D, 7'h00, 1'b0);
    go(177); pin("d2_4", 6'h3B, 7'h19, 1'b1);
    go(181); pin("dash_d3", 6'h37, 7'h3F, 1'b0);
    go(185); pin("d4_5", 6'h2F, 7'h12, 1'b1);
    go(189); pin("d5_7", 6'h1F, 7'h78, 1'b1);
    go(209);
    reset = 1'b1; hour = 8'h21;
    @(negedge clk);
    pin("mid_rst_a", 6'h3F, 7'h7F, 1'b1);
    chk("mid_rst_b", {an_b, seg_b, dp_b}, {6'h3F, 7'h7F, 1'b1});
    reset = 1'b0;
    go(0);   pin("r_n0", 6'h3F, 7'h7F, 1'b1);
    go(1);   pin("r_d0", 6'h3E, 7'h24, 1'b1);
    go(5);   pin("r_d1", 6'h3D, 7'h79, 1'b0);
    go(40);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
